// File: rtl/fsm_seq_detect_pkg.sv
// Shared defaults and types for the serial pattern detectors.
// The optional match counter is enabled by defining FSM_MATCH_COUNT_EN.
package fsm_seq_detect_pkg;

    localparam int         DEF_N       = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    localparam int         DEF_COUNT_W = 8;

    typedef enum logic {
        MODE_NONOVERLAP = 1'b0,
        MODE_OVERLAP    = 1'b1
    } match_mode_e;

endpackage

// File: rtl/fsm_seq_detect_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
// Used by the detectors when FSM_MATCH_COUNT_EN is defined.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register: increments on inc and sticks at the maximum value
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fsm_seq_detect.sv
// Parametrised Moore serial pattern detector with overlapping or non-overlapping matching.
// Defining FSM_MATCH_COUNT_EN adds a saturating match_count output.
module fsm_seq_detect
    import fsm_seq_detect_pkg::*;
#(
    parameter int           N       = DEF_N,
    parameter logic [N-1:0] PATTERN = N'(DEF_PATTERN),
    parameter bit           OVERLAP = 1'b1,
    parameter int           COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in,
    output logic               out
`ifdef FSM_MATCH_COUNT_EN
    ,
    output logic [COUNT_W-1:0] match_count
`endif
);

    localparam int               FILL_W    = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam match_mode_e      MODE      = OVERLAP ? MODE_OVERLAP : MODE_NONOVERLAP;

    if (N < 2) begin : g_bad_n
        $error("fsm_seq_detect: N must be at least 2");
    end
    if (COUNT_W < 1) begin : g_bad_count_w
        $error("fsm_seq_detect: COUNT_W must be at least 1");
    end

    logic [N-1:0]      hist_r;
    logic [N-1:0]      hist_n_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_inc_s;
    logic [FILL_W-1:0] fill_n_s;
    logic              hit_s;
    logic              out_n_s;
    logic              out_r;

    // Next-state: shift in the sample and decide whether this edge completes a match
    always_comb begin
        hist_n_s   = hist_r;
        fill_inc_s = fill_r;
        fill_n_s   = fill_r;
        hit_s      = 1'b0;
        if (en) begin
            hist_n_s = {hist_r[N-2:0], in};
            if (fill_r == FILL_FULL) begin
                fill_inc_s = FILL_FULL;
            end else begin
                fill_inc_s = fill_r + FILL_W'(1);
            end
            // fill gates the compare so a reset hist never counts as pattern bits
            hit_s = (fill_inc_s == FILL_FULL) && (hist_n_s == PATTERN);
            if (hit_s && (MODE == MODE_NONOVERLAP)) begin
                fill_n_s = '0;
            end else begin
                fill_n_s = fill_inc_s;
            end
        end else begin
            hist_n_s = hist_r;
            fill_n_s = fill_r;
        end
    end

    // Output decode: a single-cycle pulse per enabled match
    always_comb begin
        out_n_s = 1'b0;
        if (hit_s) begin
            out_n_s = 1'b1;
        end else begin
            out_n_s = 1'b0;
        end
    end

    // State register: reset dominates en and in
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_r <= '0;
            fill_r <= '0;
            out_r  <= 1'b0;
        end else begin
            hist_r <= hist_n_s;
            fill_r <= fill_n_s;
            out_r  <= out_n_s;
        end
    end

    assign out = out_r;

`ifdef FSM_MATCH_COUNT_EN
    sat_counter #(
        .WIDTH (COUNT_W)
    ) u_match_count (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_s),
        .count (match_count)
    );
`endif

endmodule

// File: tb/tb_fsm_seq_detect.sv
// Directed bench for fsm_seq_detect: overlap, non-overlap and all-zero pattern instances
// share one stimulus stream; a standalone sat_counter covers saturation.
module tb_fsm_seq_detect;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic in = 1'b0;
    logic inc = 1'b0;
    logic out_a;
    logic out_b;
    logic out_c;
    logic [1:0] sat_count;
    int tests_run = 0;
    int tests_failed = 0;

`ifdef FSM_MATCH_COUNT_EN
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [7:0] cnt_c;
`endif

    always #5 clk = ~clk;

    fsm_seq_detect dut_a (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .in    (in),
        .out   (out_a)
`ifdef FSM_MATCH_COUNT_EN
        ,
        .match_count (cnt_a)
`endif
    );

    fsm_seq_detect #(.OVERLAP(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .in    (in),
        .out   (out_b)
`ifdef FSM_MATCH_COUNT_EN
        ,
        .match_count (cnt_b)
`endif
    );

    fsm_seq_detect #(.PATTERN(4'b0000)) dut_c (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .in    (in),
        .out   (out_c)
`ifdef FSM_MATCH_COUNT_EN
        ,
        .match_count (cnt_c)
`endif
    );

    sat_counter #(.WIDTH(2)) u_sat (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .count (sat_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic e, input logic b);
        en = e;
        in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick(1'b1, 1'b1);
        end
        reset = 1'b0;
        check_val("rst_a", 32'(out_a), 32'd0);
        check_val("rst_b", 32'(out_b), 32'd0);
        check_val("rst_c", 32'(out_c), 32'd0);
`ifdef FSM_MATCH_COUNT_EN
        check_val("rst_cnt_a", 32'(cnt_a), 32'd0);
`endif
    endtask

    // Feed bits MSB-first with en=1 and compare each instance after every edge
    task automatic run_seq(input string tag, input int len, input logic [15:0] bits,
                           input logic [15:0] exp_a, input logic [15:0] exp_b,
                           input logic [15:0] exp_c);
        for (int i = len - 1; i >= 0; i--) begin
            tick(1'b1, bits[i]);
            check_val($sformatf("%s_a%0d", tag, len - i), 32'(out_a), 32'(exp_a[i]));
            check_val($sformatf("%s_b%0d", tag, len - i), 32'(out_b), 32'(exp_b[i]));
            check_val($sformatf("%s_c%0d", tag, len - i), 32'(out_c), 32'(exp_c[i]));
        end
    endtask

    initial begin
        // 1: basic match, pulse lasts one cycle
        do_reset(2);
        run_seq("t1", 4, 16'b1101, 16'b0001, 16'b0001, 16'b0000);
        tick(1'b0, 1'b0);
        check_val("t1_pulse_end", 32'(out_a), 32'd0);
`ifdef FSM_MATCH_COUNT_EN
        check_val("t1_cnt_a", 32'(cnt_a), 32'd1);
`endif

        // 2: overlapping vs non-overlapping
        do_reset(1);
        run_seq("t2", 7, 16'b1101101, 16'b0001001, 16'b0001000, 16'b0000000);
`ifdef FSM_MATCH_COUNT_EN
        check_val("t2_cnt_a", 32'(cnt_a), 32'd2);
        check_val("t2_cnt_b", 32'(cnt_b), 32'd1);
`endif

        // 3: en=0 gaps hold history and force out low
        do_reset(1);
        run_seq("t3a", 2, 16'b11, 16'b00, 16'b00, 16'b00);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'(i % 2));
            check_val($sformatf("t3_gap%0d_a", i), 32'(out_a), 32'd0);
        end
        run_seq("t3b", 2, 16'b01, 16'b01, 16'b01, 16'b00);

        // 4: all-zero pattern needs four real samples, then matches back-to-back
        do_reset(1);
        run_seq("t4", 6, 16'b000000, 16'b000000, 16'b000000, 16'b000111);
        tick(1'b0, 1'b0);
        check_val("t4_gap_c", 32'(out_c), 32'd0);
        tick(1'b1, 1'b0);
        check_val("t4_resume_c", 32'(out_c), 32'd1);

        // 5: reset mid-sequence discards the partial match
        do_reset(1);
        run_seq("t5a", 3, 16'b110, 16'b000, 16'b000, 16'b000);
        do_reset(1);
        run_seq("t5b", 5, 16'b11101, 16'b00001, 16'b00001, 16'b00000);

        // 6: two-bit saturating counter holds at 3
        do_reset(1);
        check_val("t6_sat0", 32'(sat_count), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            inc = 1'b1;
            tick(1'b0, 1'b0);
            check_val($sformatf("t6_sat%0d", i), 32'(sat_count), (i > 3) ? 32'd3 : 32'(i));
        end
        inc = 1'b0;
        tick(1'b0, 1'b0);
        check_val("t6_sat_hold", 32'(sat_count), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
